// File: rtl/mult_pkg.sv
// Shared constants, state encoding and pair-count helper for the sequential
// digit-serial multiplier.
package mult_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Number of digit pairs visited: all N*N pairs, or only those with i+j >= N-1.
  function automatic int pair_count(input int n, input logic approx);
    if (approx) return (n * (n + 1)) / 2;
    else        return n * n;
  endfunction

endpackage

// File: rtl/mult_accurate.sv
// Combinational 4x4 unsigned digit multiplier.
module mult_accurate
  import mult_pkg::*;
(
  input  logic [DIGIT_W-1:0]   a,
  input  logic [DIGIT_W-1:0]   b,
  output logic [2*DIGIT_W-1:0] prod
);

  assign prod = {{DIGIT_W{1'b0}}, a} * {{DIGIT_W{1'b0}}, b};

endmodule

// File: rtl/mult_seq_nxn.sv
// Iterative WIDTHxWIDTH unsigned multiplier: one 4x4 digit product per clock,
// shifted and accumulated into a 2*WIDTH result, with optional approximate mode.
module mult_seq_nxn
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] PROD,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and stays
  // high with PROD stable until out_ready is seen.

  localparam int N    = WIDTH / DIGIT_W;
  localparam int CW   = $clog2(N);
  localparam int KW   = $clog2(N * N) + 1;
  localparam int SHW  = $clog2(2 * WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               ap_r;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      i_idx, j_idx;
  logic [KW-1:0]      cnt;
  logic [DIGIT_W-1:0] a_dig, b_dig;
  logic [2*DIGIT_W-1:0] dprod;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] term;
  logic               accept, last_pair;

  // First A digit visited in row j; in approx mode rows start at N-1-j.
  function automatic logic [CW-1:0] start_i(input logic [CW-1:0] jj, input logic ap);
    if (ap) return CW'(N - 1) - jj;
    else    return '0;
  endfunction

  assign accept    = in_valid && (state == S_IDLE);
  assign last_pair = (cnt == '0);

  assign a_dig = a_r[{i_idx, 2'b00} +: DIGIT_W];
  assign b_dig = b_r[{j_idx, 2'b00} +: DIGIT_W];

  mult_accurate u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .prod (dprod)
  );

  assign shamt = SHW'({i_idx, 2'b00}) + SHW'({j_idx, 2'b00});
  assign term  = {{(2*WIDTH-2*DIGIT_W){1'b0}}, dprod} << shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_CALC;
      S_CALC:  if (last_pair) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_CALC) || (state == S_DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      ap_r  <= 1'b0;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      cnt   <= '0;
    end else if (accept) begin
      a_r   <= A;
      b_r   <= B;
      ap_r  <= approx;
      acc   <= '0;
      i_idx <= start_i('0, approx);
      j_idx <= '0;
      cnt   <= KW'(pair_count(N, approx) - 1);
    end else if (state == S_CALC) begin
      acc <= acc + term;
      cnt <= cnt - KW'(1);
      if (i_idx == CW'(N - 1)) begin
        j_idx <= j_idx + CW'(1);
        i_idx <= start_i(j_idx + CW'(1), ap_r);
      end else begin
        i_idx <= i_idx + CW'(1);
      end
    end
  end

  assign PROD = acc;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Directed and randomized bench for mult_seq_nxn (WIDTH=16 plus a WIDTH=8 copy),
// checked against a digit-sum reference model and an expected-result queue.
module tb_mult_seq_nxn;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, approx = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] prod;
  logic [1:0]  state_dbg;

  logic        v8 = 1'b0, ordy8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, ov8, busy8;
  logic [15:0] prod8;
  logic [1:0]  dbg8;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  mult_seq_nxn #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .approx(approx), .out_valid(out_valid),
    .out_ready(out_ready), .PROD(prod), .busy(busy), .state_dbg(state_dbg)
  );

  mult_seq_nxn #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .A(a8), .B(b8), .approx(1'b0), .out_valid(ov8),
    .out_ready(ordy8), .PROD(prod8), .busy(busy8), .state_dbg(dbg8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of visited digit products, each weighted by 16^(i+j).
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ap, output int k);
    logic [63:0] s;
    logic [63:0] ad, bd;
    s = 0;
    k = 0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (!ap || (i + j >= 3)) begin
          ad = (64'(a) / (64'd1 << (4 * i))) % 64'd16;
          bd = (64'(b) / (64'd1 << (4 * j))) % 64'd16;
          s  = s + ad * bd * (64'd1 << (4 * (i + j)));
          k++;
        end
      end
    end
    return s[31:0];
  endfunction

  // Issue one operand pair, wait for the result, hold backpressure, retire.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ap, input int hold);
    int n;
    logic [31:0] exp;
    int lat;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; a_in = a; b_in = b; approx = ap;
    @(negedge clk);
    in_valid = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom); approx = 1'($urandom);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    exp = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({tag, "_latency"}, n, lat);
    check({tag, "_prod"}, prod, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_prod"}, prod, exp);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retire_valid"}, out_valid, 1'b0);
    check({tag, "_retire_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [31:0] m;
    int k, n;
    logic [15:0] ra, rb;
    logic rap;

    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_prod", prod, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    exp_q.push_back(32'hFFFE0001); lat_q.push_back(16);
    run_op("acc_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 0);
    exp_q.push_back(32'h06260060); lat_q.push_back(16);
    run_op("acc_1234", 16'h1234, 16'h5678, 1'b0, 0);
    exp_q.push_back(32'h00000000); lat_q.push_back(10);
    run_op("apx_000f", 16'h000F, 16'h000F, 1'b1, 0);
    exp_q.push_back(32'hE1000000); lat_q.push_back(10);
    run_op("apx_f000", 16'hF000, 16'hF000, 1'b1, 0);
    exp_q.push_back(32'(32'hABCD * 32'h1111)); lat_q.push_back(16);
    run_op("bp", 16'hABCD, 16'h1111, 1'b0, 5);

    // Reset in the middle of a calculation.
    in_valid = 1'b1; a_in = 16'hBEEF; b_in = 16'hCAFE; approx = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_prod", prod, 32'h0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'(32'h0003 * 32'h0007)); lat_q.push_back(16);
    run_op("post_rst", 16'h0003, 16'h0007, 1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      ra = 16'($urandom); rb = 16'($urandom); rap = 1'($urandom_range(0, 1));
      m = model(ra, rb, rap, k);
      exp_q.push_back(m); lat_q.push_back(k);
      if (!rap) check("rand_model_exact", m, 32'(ra) * 32'(rb));
      else      check("rand_apx_le_exact", (m <= 32'(ra) * 32'(rb)), 1'b1);
      run_op("rand", ra, rb, rap, $urandom_range(0, 2));
    end

    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    v8 = 1'b0;
    n = 0;
    while (!ov8 && n < 100) begin @(negedge clk); n++; end
    check("w8_latency", n, 4);
    check("w8_prod", prod8, 16'hFE01);
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check("w8_retire", ov8, 1'b0);
    check("w8_in_ready", rdy8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
